// File: rtl/lut_eval_if.sv
// Bus bundle for lut_eval: table-load channel, evaluation channel and,
// when LUT_EVAL_READBACK_EN is defined, the table readback port.
interface lut_eval_if #(
  parameter int N = 4
) ();
  logic         cfg_start;
  logic         cfg_valid;
  logic         cfg_bit;
  logic         cfg_busy;
  logic         cfg_done;
  logic         in_valid;
  logic [N-1:0] in_vec;
  logic         in_ready;
  logic         out_valid;
  logic         out_f;
`ifdef LUT_EVAL_READBACK_EN
  logic [N-1:0] rd_addr;
  logic         rd_data;

  modport master (
    output cfg_start, cfg_valid, cfg_bit, in_valid, in_vec, rd_addr,
    input  cfg_busy, cfg_done, in_ready, out_valid, out_f, rd_data
  );
  modport slave (
    input  cfg_start, cfg_valid, cfg_bit, in_valid, in_vec, rd_addr,
    output cfg_busy, cfg_done, in_ready, out_valid, out_f, rd_data
  );
`else
  modport master (
    output cfg_start, cfg_valid, cfg_bit, in_valid, in_vec,
    input  cfg_busy, cfg_done, in_ready, out_valid, out_f
  );
  modport slave (
    input  cfg_start, cfg_valid, cfg_bit, in_valid, in_vec,
    output cfg_busy, cfg_done, in_ready, out_valid, out_f
  );
`endif
endinterface

// File: rtl/lut_eval.sv
// N-input lookup-table evaluator: serially loaded 2^N-bit truth table, then
// one registered evaluation per cycle. Optional readback: LUT_EVAL_READBACK_EN.
module lut_eval #(
  parameter int N = 4
) (
  input  logic          clk,
  input  logic          rst,
  lut_eval_if.slave     lut_if,
  output logic [1:0]    state_o
);
  localparam int DEPTH = 1 << N;

  // Handshakes: a table bit transfers on a LOAD cycle with cfg_valid=1 and
  // cfg_start=0; an evaluation transfers on any cycle with in_valid && in_ready,
  // and its result appears with out_valid exactly one cycle later.
  typedef enum logic [1:0] {
    ST_UNCFG = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     cnt_q, cnt_d;
  logic [DEPTH-1:0] table_q, table_d;
  logic             cfg_done_q, cfg_done_d;
  logic             out_valid_q, out_valid_d;
  logic             out_f_q, out_f_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    table_d     = table_q;
    cfg_done_d  = 1'b0;
    out_valid_d = 1'b0;
    out_f_d     = out_f_q;
    unique case (state_q)
      ST_UNCFG: begin
        if (lut_if.cfg_start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        // A restart discards any bit presented in the same cycle.
        if (lut_if.cfg_start) begin
          cnt_d = '0;
        end else if (lut_if.cfg_valid) begin
          table_d[cnt_q] = lut_if.cfg_bit;
          cnt_d          = cnt_q + N'(1);
          if (cnt_q == {N{1'b1}}) begin
            state_d    = ST_RUN;
            cfg_done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // The table is only rewritten from LOAD, so an evaluation accepted
        // alongside cfg_start still sees the old contents.
        if (lut_if.in_valid) begin
          out_valid_d = 1'b1;
          out_f_d     = table_q[lut_if.in_vec];
        end
        if (lut_if.cfg_start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_UNCFG;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_UNCFG;
      cnt_q       <= '0;
      table_q     <= '0;
      cfg_done_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_f_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      table_q     <= table_d;
      cfg_done_q  <= cfg_done_d;
      out_valid_q <= out_valid_d;
      out_f_q     <= out_f_d;
    end
  end

  assign lut_if.cfg_busy  = (state_q == ST_LOAD);
  assign lut_if.in_ready  = (state_q == ST_RUN);
  assign lut_if.cfg_done  = cfg_done_q;
  assign lut_if.out_valid = out_valid_q;
  assign lut_if.out_f     = out_f_q;
  assign state_o          = state_q;

`ifdef LUT_EVAL_READBACK_EN
  logic rd_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= 1'b0;
    end else begin
      rd_data_q <= table_q[lut_if.rd_addr];
    end
  end

  assign lut_if.rd_data = rd_data_q;
`endif
endmodule

// File: tb/tb_lut_eval.sv
// Self-checking bench for lut_eval (N=4): directed load/evaluate scenarios
// followed by randomized traffic against a transaction-level model.
module tb_lut_eval;
  logic       clk;
  logic       rst;
  logic [1:0] state_o;

  lut_eval_if #(.N(4)) lut_if ();

  lut_eval #(.N(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .lut_if  (lut_if),
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard and model ----------------
  int          tests_run;
  int          tests_failed;
  logic        exp_q[$];
  logic [15:0] m_mem;
  int          m_cnt;
  bit          m_load;
  bit          m_run;
  logic        m_last_f;
`ifdef LUT_EVAL_READBACK_EN
  logic [3:0]  rd_sel;
`endif

  task automatic check(input string tag, input logic obs, input logic exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic s, input logic v, input logic b,
                       input logic iv, input logic [3:0] vec);
    logic exp_eval;
    logic exp_done;
`ifdef LUT_EVAL_READBACK_EN
    logic exp_rd;
    lut_if.rd_addr = rd_sel;
    exp_rd         = m_mem[rd_sel];
`endif
    lut_if.cfg_start = s;
    lut_if.cfg_valid = v;
    lut_if.cfg_bit   = b;
    lut_if.in_valid  = iv;
    lut_if.in_vec    = vec;
    exp_eval = 1'b0;
    exp_done = 1'b0;
    if (m_run && iv) begin
      exp_q.push_back(m_mem[vec]);
      exp_eval = 1'b1;
    end
    if (s) begin
      m_load = 1'b1;
      m_run  = 1'b0;
      m_cnt  = 0;
    end else if (v && m_load) begin
      m_mem[m_cnt] = b;
      m_cnt++;
      if (m_cnt == 16) begin
        m_load   = 1'b0;
        m_run    = 1'b1;
        m_cnt    = 0;
        exp_done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", lut_if.out_valid, exp_eval);
    if (exp_eval) m_last_f = exp_q.pop_front();
    check("out_f", lut_if.out_f, m_last_f);
    check("cfg_done", lut_if.cfg_done, exp_done);
    check("in_ready", lut_if.in_ready, m_run);
    check("cfg_busy", lut_if.cfg_busy, m_load);
`ifdef LUT_EVAL_READBACK_EN
    check("rd_data", lut_if.rd_data, exp_rd);
`endif
  endtask

  task automatic apply_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      rst              = 1'b1;
      lut_if.cfg_start = 1'($urandom);
      lut_if.cfg_valid = 1'($urandom);
      lut_if.cfg_bit   = 1'($urandom);
      lut_if.in_valid  = 1'($urandom);
      lut_if.in_vec    = 4'($urandom);
`ifdef LUT_EVAL_READBACK_EN
      lut_if.rd_addr   = 4'($urandom);
`endif
      @(posedge clk);
      #1;
    end
    rst      = 1'b0;
    m_mem    = '0;
    m_cnt    = 0;
    m_load   = 1'b0;
    m_run    = 1'b0;
    m_last_f = 1'b0;
    exp_q.delete();
    check("rst_in_ready", lut_if.in_ready, 1'b0);
    check("rst_out_valid", lut_if.out_valid, 1'b0);
    check("rst_out_f", lut_if.out_f, 1'b0);
    check("rst_cfg_busy", lut_if.cfg_busy, 1'b0);
    check("rst_cfg_done", lut_if.cfg_done, 1'b0);
    check("rst_state_uncfg", state_o == 2'd0, 1'b1);
`ifdef LUT_EVAL_READBACK_EN
    check("rst_rd_data", lut_if.rd_data, 1'b0);
`endif
  endtask

  task automatic load_word(input logic [15:0] w);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, w[i], 1'b0, 4'h0);
  endtask

  task automatic eval(input logic [3:0] vec);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, vec);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] seq_exp;
  logic [15:0] rnd_w;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst              = 1'b1;
    lut_if.cfg_start = 1'b0;
    lut_if.cfg_valid = 1'b0;
    lut_if.cfg_bit   = 1'b0;
    lut_if.in_valid  = 1'b0;
    lut_if.in_vec    = '0;
`ifdef LUT_EVAL_READBACK_EN
    rd_sel         = '0;
    lut_if.rd_addr = '0;
`endif
    apply_reset(2);

    // Evaluation before any configuration is ignored.
    eval(4'hF);

    load_word(16'h8DC5);
    check("done_after_16th", lut_if.cfg_done, 1'b1);
    check("ready_after_load", lut_if.in_ready, 1'b1);
    eval(4'b0110);
    check("eval_0110", lut_if.out_f, 1'b1);
    eval(4'b0101);
    check("eval_0101", lut_if.out_f, 1'b0);

    seq_exp = 16'b1000_1101_1100_0101;
    for (int i = 0; i < 16; i++) begin
      eval(4'(i));
      check("sweep_valid", lut_if.out_valid, 1'b1);
      check("sweep_f", lut_if.out_f, seq_exp[i]);
    end

`ifdef LUT_EVAL_READBACK_EN
    rd_sel = 4'd11;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    check("rd_11", lut_if.rd_data, 1'b1);
    rd_sel = 4'd12;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    check("rd_12", lut_if.rd_data, 1'b0);
`endif

    // Reload from RUN with an evaluation in the same cycle (old table).
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 4'd6);
    check("eval_on_restart", lut_if.out_f, 1'b1);
    // Partial load, restart (with a discarded bit), then full load.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, (i == 0), 1'b0, 4'h0);
      if (i < 15) check("no_early_done", lut_if.cfg_done, 1'b0);
    end
    check("done_second_seq", lut_if.cfg_done, 1'b1);
    eval(4'd0);
    check("eval_0_after_reload", lut_if.out_f, 1'b1);
    eval(4'd4);
    check("eval_4_after_reload", lut_if.out_f, 1'b0);

    // Reset in the middle of a load.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    apply_reset(1);
    for (int i = 0; i < 16; i++) begin
`ifdef LUT_EVAL_READBACK_EN
      rd_sel = 4'(i);
`endif
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'(i));
      check("after_abort_uncfg", lut_if.in_ready, 1'b0);
    end

    // Randomized traffic with occasional restarts and resets.
    rnd_w = 16'($urandom);
    load_word(rnd_w);
    for (int n = 0; n < 3000; n++) begin
`ifdef LUT_EVAL_READBACK_EN
      rd_sel = 4'($urandom);
`endif
      if ($urandom_range(0, 299) == 0) begin
        apply_reset(1 + $urandom_range(0, 1));
      end else begin
        cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
              1'($urandom), 1'($urandom), 4'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/lut_eval.md
LUT_EVAL -- requirements
Module: lut_eval

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter N, default 4: number of function inputs; legal range 2..8.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cfg_start  input  1  one-cycle pulse that begins a truth-table load.
REQ-006 cfg_valid  input  1  qualifies cfg_bit.
REQ-007 cfg_bit  input  1  next truth-table bit, index 0 first.
REQ-008 cfg_busy  output  1  high while a load is in progress.
REQ-009 cfg_done  output  1  one-cycle pulse when a load completes.
REQ-010 in_valid  input  1  qualifies in_vec.
REQ-011 in_vec  input  N  input combination; in_vec[N-1] is the MSB of the table index.
REQ-012 in_ready  output  1  high when evaluations are accepted.
REQ-013 out_valid  output  1  one-cycle pulse marking a new result.
REQ-014 out_f  output  1  function value for the last accepted in_vec.

Function
REQ-015 The block SHALL hold a 2^N-bit truth table and a three-state FSM: UNCFG, LOAD, RUN.
REQ-016 UNCFG: in_ready=0, cfg_busy=0; cfg_start moves to LOAD; in_valid and cfg_valid are ignored.
REQ-017 LOAD: cfg_busy=1, in_ready=0; each cfg_valid cycle writes cfg_bit to table[cnt] and increments the N-bit counter cnt from 0.
REQ-018 The write at cnt=2^N-1 SHALL move to RUN and assert cfg_done on the following cycle; cnt wraps to 0.
REQ-019 cfg_start while in LOAD SHALL reset cnt to 0 and stay in LOAD; bits already written are overwritten by the new sequence.
REQ-020 cfg_start and cfg_valid in the same LOAD cycle: restart wins and cfg_bit is discarded.
REQ-021 RUN: in_ready=1; in_valid SHALL produce out_valid=1 and out_f=table[in_vec] exactly one cycle later, one result per cycle, with no bubbles.
REQ-022 out_f SHALL hold its value between accepted evaluations.
REQ-023 cfg_start in RUN SHALL enter LOAD next cycle; an in_valid in that same cycle is accepted and evaluated against the old table.
REQ-024 A partial load (LOAD left only by rst) SHALL never be used for evaluation.

Reset
REQ-025 On rst the state SHALL be UNCFG, cnt=0, table all 0, and cfg_busy, cfg_done, in_ready, out_valid, out_f all 0.
REQ-026 rst SHALL override all other inputs in the same cycle, including mid-load and mid-evaluation; no out_valid or cfg_done follows a reset cycle.

Configuration
REQ-027 Macro LUT_EVAL_READBACK_EN defined: ports rd_addr (input, N) and rd_data (output, 1) SHALL exist; rd_data = table[rd_addr] registered with 1-cycle latency in any state; rd_data=0 on reset.
REQ-028 Macro LUT_EVAL_READBACK_EN undefined: the ports and readback logic SHALL be absent; all other behaviour is identical.

Verification
REQ-029 Assert rst for 2 cycles -> in_ready=0, out_valid=0, out_f=0, cfg_busy=0; in_valid with in_vec=4'hF -> no out_valid.
REQ-030 N=4: cfg_start, then 16 cfg_valid bits of 16'h8DC5, LSB first -> cfg_done one cycle after the 16th bit, in_ready=1. Then in_vec=4'b0110 -> out_f=1, and 4'b0101 -> out_f=0, each one cycle later.
REQ-031 After the 16'h8DC5 load, drive in_vec 0..15 on consecutive cycles -> 16 consecutive out_valid pulses with out_f = 1,0,1,0,0,0,1,1,1,0,1,1,0,0,0,1.
REQ-032 cfg_start, 5 bits of 1s, cfg_start again, then 16 bits of 16'h0001 -> cfg_done only after the second sequence; in_vec=0 -> 1, in_vec=4 -> 0.
REQ-033 Assert rst after 8 of 16 bits -> UNCFG, in_ready=0, cfg_done never pulses, table reads 0.
REQ-034 With LUT_EVAL_READBACK_EN defined, after the 16'h8DC5 load: rd_addr=11 -> rd_data=1 one cycle later; rd_addr=12 -> rd_data=0.
